// File: rtl/mc_control.sv
// Multicycle control FSM for the MIPS-subset datapath: holds the fetched
// instruction and sequences fetch, decode, ALU, memory and writeback steps.
module mc_control #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        instr,
   input  logic               ALU_zero,
   input  logic               mem_ack,
   output logic [31:0]        IR,
   output logic               IR_en,
   output logic               PC_sel,
   output logic               PC_LdEn,
   output logic               RFwen,
   output logic               RFsel_write,
   output logic               RFsel_B,
   output logic               ALU_Bin_sel,
   output logic [3:0]         ALU_func,
   output logic               mem_req,
   output logic               MEM_wen,
   output logic               ByteOp,
   output logic               retire,
   output logic               illegal,
   output logic [COUNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
   } state_t;

   typedef enum logic [3:0] {
      C_RTYPE,
      C_LI,
      C_LUI,
      C_ADDI,
      C_ANDI,
      C_ORI,
      C_B,
      C_BEQ,
      C_BNE,
      C_LB,
      C_LW,
      C_SB,
      C_SW,
      C_ILL
   } cls_t;

   localparam logic [3:0] FN_ADD = 4'b0000;
   localparam logic [3:0] FN_SUB = 4'b0001;
   localparam logic [3:0] FN_AND = 4'b0010;
   localparam logic [3:0] FN_OR  = 4'b0011;

   state_t               state_q, state_d;
   logic [31:0]          ir_q, ir_d;
   logic [COUNT_W-1:0]   count_q, count_d;

   cls_t                 cls;
   logic                 is_load, is_store, is_byte, is_mem, is_cond_br;
   logic                 exec_bin;
   logic [3:0]           exec_func;

   function automatic cls_t decode_op(input logic [5:0] op);
      cls_t c;
      case (op)
         6'b100000: c = C_RTYPE;
         6'b111000: c = C_LI;
         6'b111001: c = C_LUI;
         6'b110000: c = C_ADDI;
         6'b110010: c = C_ANDI;
         6'b110011: c = C_ORI;
         6'b111111: c = C_B;
         6'b000000: c = C_BEQ;
         6'b000001: c = C_BNE;
         6'b000011: c = C_LB;
         6'b001111: c = C_LW;
         6'b000111: c = C_SB;
         6'b011111: c = C_SW;
         default:   c = C_ILL;
      endcase
      return c;
   endfunction

   // Instruction class and the ALU selects it implies, held from EXEC onward
   always_comb begin
      cls        = decode_op(ir_q[31:26]);
      is_load    = (cls == C_LB) || (cls == C_LW);
      is_store   = (cls == C_SB) || (cls == C_SW);
      is_byte    = (cls == C_LB) || (cls == C_SB);
      is_mem     = is_load || is_store;
      is_cond_br = (cls == C_BEQ) || (cls == C_BNE);
      exec_bin   = 1'b1;
      exec_func  = FN_ADD;
      case (cls)
         C_RTYPE: begin
            exec_bin  = 1'b0;
            exec_func = ir_q[3:0];
         end
         C_ANDI:  exec_func = FN_AND;
         C_ORI:   exec_func = FN_OR;
         C_BEQ, C_BNE: begin
            exec_bin  = 1'b0;
            exec_func = FN_SUB;
         end
         default: begin
            exec_bin  = 1'b1;
            exec_func = FN_ADD;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      IR_en       = 1'b0;
      PC_sel      = 1'b0;
      PC_LdEn     = 1'b0;
      RFwen       = 1'b0;
      RFsel_write = 1'b0;
      RFsel_B     = 1'b0;
      ALU_Bin_sel = 1'b0;
      ALU_func    = FN_ADD;
      mem_req     = 1'b0;
      MEM_wen     = 1'b0;
      ByteOp      = 1'b0;
      retire      = 1'b0;
      illegal     = 1'b0;
      case (state_q)
         S_FETCH: begin
            IR_en   = 1'b1;
            PC_LdEn = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            RFsel_B = is_cond_br || is_store;
            if (cls == C_B) begin
               PC_sel  = 1'b1;
               PC_LdEn = 1'b1;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (cls == C_ILL) begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            ALU_Bin_sel = exec_bin;
            ALU_func    = exec_func;
            if (is_cond_br) begin
               // Only output that looks at a live datapath flag
               RFsel_B = 1'b1;
               PC_sel  = 1'b1;
               PC_LdEn = (cls == C_BNE) ? ~ALU_zero : ALU_zero;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (is_mem) begin
               RFsel_B = is_store;
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            ALU_Bin_sel = 1'b1;
            ALU_func    = FN_ADD;
            mem_req     = 1'b1;
            MEM_wen     = is_store;
            ByteOp      = is_byte;
            RFsel_B     = is_store;
            if (mem_ack) begin
               if (is_store) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            RFwen       = 1'b1;
            RFsel_write = is_load;
            if (!is_load) begin
               ALU_Bin_sel = exec_bin;
               ALU_func    = exec_func;
            end
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      ir_d    = IR_en ? instr : ir_q;
      count_d = retire ? (count_q + COUNT_W'(1)) : count_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         ir_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         count_q <= count_d;
      end
   end

   assign IR          = ir_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle expected control words go through a
// scoreboard queue and are compared against the outputs mid-cycle.
module tb_mc_control;

   localparam int CW = 4;

   localparam logic [15:0] B_IREN  = 16'h8000;
   localparam logic [15:0] B_PCSEL = 16'h4000;
   localparam logic [15:0] B_PCLD  = 16'h2000;
   localparam logic [15:0] B_RFW   = 16'h1000;
   localparam logic [15:0] B_RFSW  = 16'h0800;
   localparam logic [15:0] B_RFSB  = 16'h0400;
   localparam logic [15:0] B_BIN   = 16'h0200;
   localparam logic [15:0] F_MASK  = 16'h01E0;
   localparam logic [15:0] B_MREQ  = 16'h0010;
   localparam logic [15:0] B_MWEN  = 16'h0008;
   localparam logic [15:0] B_BYTE  = 16'h0004;
   localparam logic [15:0] B_RET   = 16'h0002;
   localparam logic [15:0] B_ILL   = 16'h0001;
   localparam logic [15:0] EN      = B_IREN | B_PCLD | B_RFW | B_MREQ | B_MWEN | B_RET | B_ILL;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   instr;
   logic          ALU_zero;
   logic          mem_ack;
   logic [31:0]   IR;
   logic          IR_en, PC_sel, PC_LdEn, RFwen, RFsel_write, RFsel_B, ALU_Bin_sel;
   logic [3:0]    ALU_func;
   logic          mem_req, MEM_wen, ByteOp, retire, illegal;
   logic [CW-1:0] instr_count;
   logic [15:0]   ctl_obs;

   always #5 clk = ~clk;

   mc_control #(.COUNT_W(CW)) dut (
      .clk(clk), .reset(reset), .instr(instr), .ALU_zero(ALU_zero), .mem_ack(mem_ack),
      .IR(IR), .IR_en(IR_en), .PC_sel(PC_sel), .PC_LdEn(PC_LdEn), .RFwen(RFwen),
      .RFsel_write(RFsel_write), .RFsel_B(RFsel_B), .ALU_Bin_sel(ALU_Bin_sel),
      .ALU_func(ALU_func), .mem_req(mem_req), .MEM_wen(MEM_wen), .ByteOp(ByteOp),
      .retire(retire), .illegal(illegal), .instr_count(instr_count)
   );

   assign ctl_obs = {IR_en, PC_sel, PC_LdEn, RFwen, RFsel_write, RFsel_B, ALU_Bin_sel,
                     ALU_func, mem_req, MEM_wen, ByteOp, retire, illegal};

   typedef struct {
      string         tag;
      logic [15:0]   ctl;
      logic [15:0]   m;
      logic [CW-1:0] cnt;
      logic [31:0]   ir;
   } exp_t;

   exp_t          sbq[$];
   int            checks = 0;
   int            errors = 0;
   logic [CW-1:0] exp_cnt;
   logic [31:0]   exp_ir;

   function automatic logic [15:0] fn(input logic [3:0] f);
      return {7'b0, f, 5'b0};
   endfunction

   // One clock cycle: drive inputs, queue the expectation, compare mid-cycle
   task automatic step(input string tag, input logic [31:0] ins, input logic z,
                       input logic ack, input logic rst, input logic [15:0] e,
                       input logic [15:0] sel, input logic [15:0] drop);
      exp_t x;
      exp_t y;
      instr    = ins;
      ALU_zero = z;
      mem_ack  = ack;
      reset    = rst;
      x.tag = tag;
      x.ctl = e;
      x.m   = (EN | sel) & ~drop;
      x.cnt = exp_cnt;
      x.ir  = exp_ir;
      sbq.push_back(x);
      #2;
      y = sbq.pop_front();
      checks++;
      assert ((ctl_obs & y.m) === (y.ctl & y.m)) else begin
         errors++;
         $error("FAIL %s ctl obs=%h exp=%h mask=%h", y.tag, ctl_obs & y.m, y.ctl & y.m, y.m);
      end
      checks++;
      assert (instr_count === y.cnt) else begin
         errors++;
         $error("FAIL %s instr_count obs=%0d exp=%0d", y.tag, instr_count, y.cnt);
      end
      checks++;
      assert (IR === y.ir) else begin
         errors++;
         $error("FAIL %s IR obs=%h exp=%h", y.tag, IR, y.ir);
      end
      if (rst) begin
         exp_cnt = '0;
         exp_ir  = '0;
      end else begin
         if ((e & B_RET) != 16'h0) exp_cnt = exp_cnt + 4'd1;
         if ((e & B_IREN) != 16'h0) exp_ir = ins;
      end
      @(negedge clk);
   endtask

   task automatic fetch(input string tag, input logic [31:0] ins);
      step({tag, "/F"}, ins, 1'b0, 1'b0, 1'b0, B_IREN | B_PCLD, B_PCSEL, 16'h0);
   endtask

   task automatic alu(input string tag, input logic [31:0] ins, input logic [3:0] f,
                      input logic bin);
      logic [15:0] s;
      s = (bin ? B_BIN : 16'h0) | fn(f);
      fetch(tag, ins);
      step({tag, "/D"}, ins, 1'b0, 1'b0, 1'b0, 16'h0, B_RFSB, 16'h0);
      step({tag, "/E"}, ins, 1'b0, 1'b0, 1'b0, s, B_BIN | F_MASK, 16'h0);
      step({tag, "/W"}, ins, 1'b0, 1'b0, 1'b0, s | B_RFW | B_RET, B_RFSW | B_BIN | F_MASK, 16'h0);
   endtask

   task automatic ldst(input string tag, input logic [31:0] ins, input logic st,
                       input logic by, input int waits, input logic ao);
      logic [15:0] mx;
      logic [15:0] ms;
      mx = B_MREQ | (st ? (B_MWEN | B_RFSB) : 16'h0) | (by ? B_BYTE : 16'h0);
      ms = B_BYTE | (st ? B_RFSB : 16'h0);
      fetch(tag, ins);
      step({tag, "/D"}, ins, 1'b0, ao, 1'b0, st ? B_RFSB : 16'h0, B_RFSB, 16'h0);
      step({tag, "/E"}, ins, 1'b0, ao, 1'b0, B_BIN | fn(4'd0), B_BIN | F_MASK, 16'h0);
      for (int i = 0; i < waits; i++)
         step({tag, "/Mw"}, ins, 1'b0, 1'b0, 1'b0, mx, ms, 16'h0);
      step({tag, "/Ma"}, ins, 1'b0, 1'b1, 1'b0, mx | (st ? B_RET : 16'h0), ms, 16'h0);
      if (!st)
         step({tag, "/W"}, ins, 1'b0, 1'b0, 1'b0, B_RFW | B_RFSW | B_RET, B_RFSW, 16'h0);
   endtask

   task automatic br(input string tag, input logic [31:0] ins, input logic is_bne,
                     input logic z);
      logic [15:0] e;
      e = fn(4'd1) | B_PCSEL | B_RET | (((is_bne ? ~z : z) == 1'b1) ? B_PCLD : 16'h0);
      fetch(tag, ins);
      step({tag, "/D"}, ins, z, 1'b0, 1'b0, B_RFSB, B_RFSB, 16'h0);
      step({tag, "/E"}, ins, z, 1'b0, 1'b0, e, B_BIN | F_MASK | B_PCSEL, 16'h0);
   endtask

   task automatic jmp(input string tag, input logic [31:0] ins);
      fetch(tag, ins);
      step({tag, "/D"}, ins, 1'b0, 1'b0, 1'b0, B_PCSEL | B_PCLD | B_RET, B_PCSEL, 16'h0);
   endtask

   initial begin
      reset    = 1'b1;
      instr    = 32'h0;
      ALU_zero = 1'b0;
      mem_ack  = 1'b0;
      exp_cnt  = '0;
      exp_ir   = '0;
      @(negedge clk);
      @(negedge clk);

      alu("add",  32'h8123_4560, 4'b0000, 1'b0);
      alu("sub",  32'h8000_0001, 4'b0001, 1'b0);
      alu("ror",  32'h80A5_5A53, 4'b0011, 1'b0);
      alu("addi", 32'hC041_0007, 4'b0000, 1'b1);
      alu("andi", 32'hC862_00FF, 4'b0010, 1'b1);
      alu("ori",  32'hCC83_F00F, 4'b0011, 1'b1);
      alu("lui",  32'hE400_1234, 4'b0000, 1'b1);
      alu("li",   32'hE020_0042, 4'b0000, 1'b1);

      ldst("lw", 32'h3C22_0010, 1'b0, 1'b0, 3, 1'b1);
      ldst("sw", 32'h7C43_0004, 1'b1, 1'b0, 0, 1'b0);
      ldst("sb", 32'h1C64_0001, 1'b1, 1'b1, 1, 1'b1);

      br("beq1", 32'h0022_0008, 1'b0, 1'b1);
      br("beq0", 32'h0022_0008, 1'b0, 1'b0);
      br("bne0", 32'h0443_FFFC, 1'b1, 1'b0);
      br("bne1", 32'h0443_FFFC, 1'b1, 1'b1);

      jmp("b_wrap", 32'hFC00_0010);

      fetch("ill", 32'hA800_0000);
      step("ill/D", 32'hA800_0000, 1'b0, 1'b0, 1'b0, B_ILL, 16'h0, 16'h0);

      jmp("b2", 32'hFC00_0020);

      // lb abandoned by reset in its second MEM wait cycle
      fetch("lbr", 32'h0C25_0003);
      step("lbr/D",   32'h0C25_0003, 1'b0, 1'b0, 1'b0, 16'h0, B_RFSB, 16'h0);
      step("lbr/E",   32'h0C25_0003, 1'b0, 1'b0, 1'b0, B_BIN, B_BIN | F_MASK, 16'h0);
      step("lbr/Mw1", 32'h0C25_0003, 1'b0, 1'b0, 1'b0, B_MREQ | B_BYTE, B_BYTE, 16'h0);
      step("lbr/Mw2", 32'h0C25_0003, 1'b0, 1'b0, 1'b1, B_MREQ | B_BYTE, B_BYTE, 16'h0);
      step("rst/F",   32'h8000_0000, 1'b0, 1'b1, 1'b0, B_IREN | B_PCLD, 16'h0, B_IREN | B_PCLD);
      step("post/D",  32'h8000_0000, 1'b0, 1'b0, 1'b0, 16'h0, B_RFSB, 16'h0);
      step("post/E",  32'h8000_0000, 1'b0, 1'b0, 1'b0, fn(4'd0), B_BIN | F_MASK, 16'h0);
      step("post/W",  32'h8000_0000, 1'b0, 1'b0, 1'b0, B_RFW | B_RET, B_RFSW | B_BIN, 16'h0);
      fetch("end", 32'h8000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
